// File: rtl/mux8_arb_pkg.sv
// Shared definitions for the 8-requester round-robin mux arbiter.
//   N      : number of requesters (fixed at 8)
//   SEL_W  : mux select width, log2(N)
//   state_t: arbiter state (IDLE = no beat presented, GRANT = beat presented)
//   onehot : index -> one-hot grant vector
package mux8_arb_pkg;

    localparam int N     = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
//   req      : request vector
//   ptr      : index scanned first; the scan continues ptr+1 .. ptr+7 (mod 8)
//   mask_idx : index to skip (the requester just served)
//   mask_en  : enables the skip
//   found    : a winner exists
//   idx      : winning index (valid when found)
// A masked requester is still picked when it is the only one requesting.
module rr_pick
    import mux8_arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [SEL_W-1:0] mask_idx,
    input  logic             mask_en,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = '0;
        // Scan from the farthest offset down so the nearest hit to ptr wins.
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand] && !(mask_en && (cand == mask_idx))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        if (!found && mask_en && req[mask_idx]) begin
            found = 1'b1;
            idx   = mask_idx;
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux output channel between 8 requesters.
// The grant is held until the beat is accepted (out_valid & out_ready), then
// priority rotates past the served requester; back-to-back beats are allowed.
// Optional feature: define MUX8_ARB_LOCK_EN to let a granted requester keep the
// channel for a burst while lock[sel] and req[sel] are high at acceptance.
//   clk, rst  : clock, synchronous active-high reset
//   req, lock : per-requester request / burst lock
//   data_in   : packed payloads, requester i at [i*DATA_W +: DATA_W]
//   gnt, sel  : registered one-hot grant and mux select
//   out_data, out_valid, out_ready : output channel
//   busy      : mirrors out_valid
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int DATA_W = 8
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        lock,
    input  logic [N*DATA_W-1:0] data_in,
    output logic [N-1:0]        gnt,
    output logic [SEL_W-1:0]    sel,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             hold;

    // While granted, arbitrate as if the pointer had already advanced, so the
    // next winner is ready on the acceptance edge.
    assign pick_ptr = (state == GRANT) ? sel + 1'b1 : ptr;

    rr_pick u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .mask_idx (sel),
        .mask_en  (state == GRANT),
        .found    (pick_found),
        .idx      (pick_idx)
    );

`ifdef MUX8_ARB_LOCK_EN
    assign hold = lock[sel] & req[sel];
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign hold        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            sel       <= '0;
            ptr       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= GRANT;
                        gnt       <= onehot(pick_idx);
                        sel       <= pick_idx;
                        out_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    // A locked acceptance keeps gnt/sel and the pointer as-is.
                    if (out_ready && !hold) begin
                        ptr <= pick_ptr;
                        if (pick_found) begin
                            gnt <= onehot(pick_idx);
                            sel <= pick_idx;
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = data_in[sel*DATA_W +: DATA_W];
    assign busy     = out_valid;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req;
    logic [7:0]  lock;
    logic [63:0] data_in;
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: whether a beat is outstanding, who holds it,
    // and the requester that gets first look at the next arbitration.
    bit m_valid;
    int m_sel;
    int m_ptr;

    always #5 clk = ~clk;

    mux8_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .data_in   (data_in),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Who wins among r, visiting requesters p, p+1, ... mod 8, skipping
    // 'skip' unless nobody else is asking. -1 means no winner.
    function automatic int pick(input logic [7:0] r, input int p, input int skip);
        int order[$];
        for (int k = 0; k < 8; k++) order.push_back((p + k) % 8);
        foreach (order[j])
            if (r[order[j]] && order[j] != skip) return order[j];
        if (skip >= 0 && r[skip]) return skip;
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        bit locked;
        if (rst) begin
            m_valid = 0; m_sel = 0; m_ptr = 0;
        end else if (!m_valid) begin
            w = pick(req, m_ptr, -1);
            if (w >= 0) begin m_valid = 1; m_sel = w; end
        end else if (out_ready) begin
            locked = 0;
`ifdef MUX8_ARB_LOCK_EN
            locked = lock[m_sel] && req[m_sel];
`endif
            if (!locked) begin
                m_ptr = (m_sel + 1) % 8;
                w = pick(req, m_ptr, m_sel);
                if (w >= 0) m_sel = w;
                else        m_valid = 0;
            end
        end
    endtask

    task automatic check_model();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_valid));
        chk("gnt", 32'(gnt), m_valid ? (32'd1 << m_sel) : 32'd0);
        if (m_valid) begin
            chk("sel", 32'(sel), 32'(m_sel));
            chk("out_data", 32'(out_data), 32'((data_in >> (m_sel * 8)) & 64'hFF));
        end
    endtask

    // Drive one cycle of inputs, advance one edge, then compare against the model.
    task automatic step(input bit r, input logic [7:0] rq, input bit rdy, input logic [7:0] lk);
        rst = r; req = rq; out_ready = rdy; lock = lk;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        int exp_lock[5];
        logic [7:0] held;
        rst = 1; req = 8'h00; lock = 8'h00; out_ready = 0;
        for (int i = 0; i < 8; i++) data_in[i*8 +: 8] = 8'h10 + 8'(i);

        // Reset with every requester active
        step(1, 8'hFF, 0, 8'h00);
        step(1, 8'hFF, 0, 8'h00);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);

        // Rotation 0..7,0 with all requesters and downstream always ready
        for (int k = 0; k < 9; k++) begin
            step(0, 8'hFF, 1, 8'h00);
            if (k == 0) chk("first_gnt", 32'(gnt), 32'h01);
            chk("rr_sel", 32'(sel), 32'(k % 8));
            chk("rr_data", 32'(out_data), 32'h10 + 32'(k % 8));
        end
        step(0, 8'h00, 1, 8'h00);          // accept 0 -> idle, next look starts at 1

        // Backpressure on requesters 2 and 5
        step(0, 8'h24, 0, 8'h00);
        chk("bp_first", 32'(sel), 32'd2);
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            step(0, 8'h24, 0, 8'h00);
            chk("bp_hold_sel", 32'(sel), 32'd2);
            chk("bp_hold_data", 32'(out_data), 32'(held));
        end
        step(0, 8'h24, 1, 8'h00);
        chk("bp_next", 32'(sel), 32'd5);
        step(0, 8'h00, 1, 8'h00);          // accept 5 -> idle, next look starts at 6

        // Wrap: serve 6, then only requester 0 remains
        step(0, 8'h40, 1, 8'h00);
        chk("wrap_six", 32'(sel), 32'd6);
        step(0, 8'h01, 1, 8'h00);
        chk("wrap_zero", 32'(sel), 32'd0);
        // Lone requester 3 is regranted every cycle
        for (int k = 0; k < 4; k++) begin
            step(0, 8'h08, 1, 8'h00);
            chk("solo_sel", 32'(sel), 32'd3);
            chk("solo_gnt", 32'(gnt), 32'h08);
        end
        step(0, 8'h00, 1, 8'h00);          // accept 3 -> idle, next look starts at 4

        // Reset in the middle of a held beat
        step(0, 8'h10, 0, 8'h00);
        chk("mid_sel", 32'(sel), 32'd4);
        step(1, 8'h10, 0, 8'h00);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        step(0, 8'h10, 0, 8'h00);
        chk("mid_regrant", 32'(sel), 32'd4);
        step(1, 8'h00, 0, 8'h00);
        step(0, 8'h11, 0, 8'h00);          // pointer back at 0 picks 0 over 4
        chk("mid_ptr0", 32'(sel), 32'd0);

        // Burst lock on requester 0 for the first four grants
        step(1, 8'h00, 0, 8'h00);
`ifdef MUX8_ARB_LOCK_EN
        exp_lock = '{0, 0, 0, 0, 1};
`else
        exp_lock = '{0, 1, 0, 1, 0};
`endif
        for (int k = 0; k < 5; k++) begin
            step(0, 8'h03, 1, (k < 4) ? 8'h01 : 8'h00);
            chk("lock_seq", 32'(sel), 32'(exp_lock[k]));
        end

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            data_in = {$urandom, $urandom};
            step(($urandom_range(0, 49) == 0), 8'($urandom), $urandom_range(0, 2) != 0,
                 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
